adder_share_arbiter: RTL and testbench

Round-robin front end that shares a single HOAANED approximate adder among `NREQ` requesters. Each requester has a valid/ready operand port. Granted operand pairs go through the adder, and the sum is returned on one registered response port tagged with the requester id. Per-requester saturating grant counters support fairness and error-budget accounting.

---
 rtl/adder_share_pkg.sv | 16 +
 rtl/adder_share_arbiter_rr_pick.sv | 33 +++
 rtl/hoaaned.sv | 28 ++
 rtl/adder_share_arbiter.sv | 116 +++++++++++
 tb/tb_adder_share_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared constants and types for the shared approximate-adder arbiter.
// Top-level parameters default to the constants defined here.
package adder_share_pkg;

    localparam int N    = 16;
    localparam int LPL  = 6;
    localparam int NREQ = 4;
    localparam int CNTW = 16;
    localparam int SUMW = N + 1;

    typedef struct packed {
        logic [$clog2(NREQ)-1:0] id;
        logic [SUMW-1:0]         sum;
    } rsp_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search begins one past the most recent winner and wraps around.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int   idx;
    logic found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx[IDW-1:0];
            end
        end
        grant_any = found;
    end

endmodule

// File: rtl/hoaaned.sv
// HOAANED approximate adder.
// The lower LPL bits are approximated; the upper UPL bits are added exactly.
module hoaaned #(
    parameter int N   = 16,
    parameter int LPL = 6,
    parameter int UPL = N - LPL
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    logic           c;
    logic [LPL-1:0] low;
    logic [UPL:0]   up;

    // The top approximate bit generates the carry into the exact part.
    always_comb begin
        low = '0;
        c   = a[LPL-1] & b[LPL-1];
        low[LPL-1] = (c ? 1'b0 : (a[LPL-1] | b[LPL-1])) | (a[LPL-2] & b[LPL-2]);
        low[LPL-2] = a[LPL-2] | b[LPL-2];
        low[0]     = 1'b1;
        up = {1'b0, a[N-1:LPL]} + {1'b0, b[N-1:LPL]} + {{UPL{1'b0}}, c};
        sum = {up, low};
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one HOAANED adder among NREQ requesters with round-robin arbitration,
// a single registered response slot and per-requester saturating grant counters.
module adder_share_arbiter #(
    parameter int N    = adder_share_pkg::N,
    parameter int LPL  = adder_share_pkg::LPL,
    parameter int NREQ = adder_share_pkg::NREQ,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = adder_share_pkg::CNTW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [N:0]           rsp_sum,
    output logic [NREQ*CNTW-1:0] grant_cnt,
    output logic                 busy
);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N:0]     sum;
    } rsp_w_t;

    logic                       rsp_valid_q, rsp_valid_d;
    rsp_w_t                     rsp_q, rsp_d;
    logic [IDW-1:0]             last_q, last_d;
    logic [NREQ-1:0][CNTW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            slot_free;
    logic            xfer;
    logic [N-1:0]    a_sel, b_sel;
    logic [N:0]      sum_w;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .last      (last_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A transfer needs a free response slot; nothing is accepted during reset.
    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        req_ready = '0;
        xfer      = 1'b0;
        if (!rst && slot_free && grant_any) begin
            req_ready = grant_oh;
            xfer      = 1'b1;
        end
        a_sel = req_a[grant_idx*N +: N];
        b_sel = req_b[grant_idx*N +: N];
    end

    hoaaned #(
        .N   (N),
        .LPL (LPL),
        .UPL (N - LPL)
    ) u_add (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum_w)
    );

    // A new transfer overwrites a response consumed in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_d.id    = grant_idx;
            rsp_d.sum   = sum_w;
            last_d      = grant_idx;
            if (cnt_q[grant_idx] != {CNTW{1'b1}}) begin
                cnt_d[grant_idx] = cnt_q[grant_idx] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            last_q      <= IDW'(NREQ - 1);
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_sum   = rsp_q.sum;
    assign grant_cnt = cnt_q;
    assign busy      = (|req_valid) || rsp_valid_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: single-requester sum vectors, then
// round-robin, stall, mid-run reset and counter-saturation sequences.
module tb_adder_share_arbiter;

    localparam int N    = 16;
    localparam int LPL  = 6;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [N:0]           rsp_sum;
    logic [NREQ*CNTW-1:0] grant_cnt;
    logic                 busy;

    int passCount;
    int checkCount;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    vec_t vecs [6];
    logic [16:0] rrSum [4];

    adder_share_arbiter #(
        .N    (N),
        .LPL  (LPL),
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .grant_cnt (grant_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setOperands(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;

        vecs[0] = '{0, 16'h0040, 16'h0040, 17'h00081};
        vecs[1] = '{1, 16'h0020, 16'h0020, 17'h00041};
        vecs[2] = '{2, 16'hFFC0, 16'h0040, 17'h10001};
        vecs[3] = '{3, 16'h0013, 16'h0005, 17'h00011};
        vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 17'h1FFF1};
        vecs[5] = '{3, 16'h1234, 16'h0F0F, 17'h02131};

        rrSum[0] = 17'h00081;
        rrSum[1] = 17'h000C1;
        rrSum[2] = 17'h00101;
        rrSum[3] = 17'h00141;

        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();

        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset rsp_sum", 64'(rsp_sum), 64'd0);
        checkOutput("reset grant_cnt", 64'(grant_cnt), 64'd0);
        req_valid = 4'b0001;
        #1;
        checkOutput("ready forced low in reset", 64'(req_ready), 64'd0);
        req_valid = 4'b0000;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            setOperands(vecs[v].id, vecs[v].a, vecs[v].b);
            applyStimulus(4'(1 << vecs[v].id), 1'b1);
            #1;
            checkOutput($sformatf("vec%0d req_ready", v), 64'(req_ready), 64'(1 << vecs[v].id));
            tick();
            applyStimulus(4'b0000, 1'b1);
            checkOutput($sformatf("vec%0d rsp_valid", v), 64'(rsp_valid), 64'd1);
            checkOutput($sformatf("vec%0d rsp_id", v), 64'(rsp_id), 64'(vecs[v].id));
            checkOutput($sformatf("vec%0d rsp_sum", v), 64'(rsp_sum), 64'(vecs[v].sum));
        end
        tick();
        checkOutput("drain rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("drain busy", 64'(busy), 64'd0);
        checkOutput("vector grant_cnt", 64'(grant_cnt), 64'h2121);

        // Round-robin with every requester asking each cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            setOperands(i, 16'(16'h0040 * (i + 1)), 16'h0040);
        end
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("rr%0d req_ready", k), 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            checkOutput($sformatf("rr%0d rsp_id", k), 64'(rsp_id), 64'(k % 4));
            checkOutput($sformatf("rr%0d rsp_sum", k), 64'(rsp_sum), 64'(rrSum[k % 4]));
        end
        checkOutput("rr grant_cnt", 64'(grant_cnt), 64'h2222);

        // Stall with all requests still pending
        tick();
        checkOutput("pre-stall rsp_id", 64'(rsp_id), 64'd0);
        applyStimulus(4'b1111, 1'b0);
        #1;
        checkOutput("stall req_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("stall%0d rsp_valid", s), 64'(rsp_valid), 64'd1);
            checkOutput($sformatf("stall%0d rsp_id", s), 64'(rsp_id), 64'd0);
            checkOutput($sformatf("stall%0d rsp_sum", s), 64'(rsp_sum), 64'(rrSum[0]));
            checkOutput($sformatf("stall%0d req_ready", s), 64'(req_ready), 64'd0);
        end
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("release req_ready", 64'(req_ready), 64'b0010);
        tick();
        checkOutput("release rsp_id", 64'(rsp_id), 64'd1);
        checkOutput("release rsp_sum", 64'(rsp_sum), 64'(rrSum[1]));
        checkOutput("stall grant_cnt", 64'(grant_cnt), 64'h2233);

        // Reset while a response is held and requests are pending
        rst = 1'b1;
        #1;
        checkOutput("midreset req_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b1100, 1'b1);
        checkOutput("midreset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midreset grant_cnt", 64'(grant_cnt), 64'd0);
        checkOutput("midreset busy", 64'(busy), 64'd1);
        #1;
        checkOutput("post-reset req_ready", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("post-reset rsp_id", 64'(rsp_id), 64'd2);
        checkOutput("post-reset rsp_sum", 64'(rsp_sum), 64'(rrSum[2]));

        // Saturation of a narrow counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b0100, 1'b1);
        for (int t = 0; t < 20; t++) begin
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sat grant_cnt", 64'(grant_cnt), 64'h0F00);
        tick();
        checkOutput("sat drain rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("sat drain busy", 64'(busy), 64'd0);

        // Priority resumes after the last winner, not after idle cycles
        tick();
        applyStimulus(4'b1011, 1'b1);
        #1;
        checkOutput("resume req_ready", 64'(req_ready), 64'b1000);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("resume rsp_id", 64'(rsp_id), 64'd3);
        checkOutput("resume rsp_sum", 64'(rsp_sum), 64'(rrSum[3]));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
